hit_resolver: RTL

HIT_RESOLVER -- requirements
Module: hit_resolver

---
 rtl/game_pkg.sv | 22 ++
 rtl/box_overlap.sv | 22 ++
 rtl/hit_resolver.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants and types for the hit resolution logic.
package game_pkg;

    localparam int unsigned COORD_W           = 10;
    localparam int unsigned STUN_W            = 5;
    localparam int unsigned STUN_MAX          = 31;
    localparam int unsigned HITSTUN_DEFAULT   = 20;
    localparam int unsigned BLOCKSTUN_DEFAULT = 12;

    // Per-attacker hitbox lifecycle: one registered hit per active window.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StSpent = 2'd2
    } atk_state_e;

    // True when a stun length is loadable into the stun counter.
    function automatic bit stun_fits(input int unsigned frames);
        return (frames >= 1) && (frames <= STUN_MAX);
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap; touching edges do not count.
module box_overlap
    import game_pkg::*;
(
    input  logic [COORD_W-1:0] i_a_x1,
    input  logic [COORD_W-1:0] i_a_x2,
    input  logic [COORD_W-1:0] i_a_y1,
    input  logic [COORD_W-1:0] i_a_y2,
    input  logic [COORD_W-1:0] i_b_x1,
    input  logic [COORD_W-1:0] i_b_x2,
    input  logic [COORD_W-1:0] i_b_y1,
    input  logic [COORD_W-1:0] i_b_y2,
    output logic               o_overlap
);

    // Strict compares on both axes so shared edges are not overlap.
    always_comb begin
        o_overlap = (i_a_x1 < i_b_x2) && (i_b_x1 < i_a_x2) &&
                    (i_a_y1 < i_b_y2) && (i_b_y1 < i_a_y2);
    end

endmodule

// File: rtl/hit_resolver.sv
// Two-player hit resolution: contact detection, once-per-window hit
// registration, block decision and stun countdown, evaluated on frame_tick.
module hit_resolver
    import game_pkg::*;
#(
    parameter int unsigned HITSTUN_FRAMES   = HITSTUN_DEFAULT,
    parameter int unsigned BLOCKSTUN_FRAMES = BLOCKSTUN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] p1_hit_x1,
    input  logic [COORD_W-1:0] p1_hit_x2,
    input  logic [COORD_W-1:0] p1_hit_y1,
    input  logic [COORD_W-1:0] p1_hit_y2,
    input  logic               p1_hit_active,
    input  logic [COORD_W-1:0] p1_hurt_x1,
    input  logic [COORD_W-1:0] p1_hurt_x2,
    input  logic [COORD_W-1:0] p1_hurt_y1,
    input  logic [COORD_W-1:0] p1_hurt_y2,
    input  logic               p1_hurt_active,
    input  logic               p1_block_req,
    input  logic [COORD_W-1:0] p2_hit_x1,
    input  logic [COORD_W-1:0] p2_hit_x2,
    input  logic [COORD_W-1:0] p2_hit_y1,
    input  logic [COORD_W-1:0] p2_hit_y2,
    input  logic               p2_hit_active,
    input  logic [COORD_W-1:0] p2_hurt_x1,
    input  logic [COORD_W-1:0] p2_hurt_x2,
    input  logic [COORD_W-1:0] p2_hurt_y1,
    input  logic [COORD_W-1:0] p2_hurt_y2,
    input  logic               p2_hurt_active,
    input  logic               p2_block_req,
    output logic               p1_got_hit,
    output logic               p1_got_block,
    output logic [STUN_W-1:0]  p1_stun_cnt,
    output logic               p1_in_hitstun,
    output logic               p2_got_hit,
    output logic               p2_got_block,
    output logic [STUN_W-1:0]  p2_stun_cnt,
    output logic               p2_in_hitstun
);

    if (!stun_fits(HITSTUN_FRAMES)) begin : g_bad_hitstun
        $error("HITSTUN_FRAMES must be in 1..31");
    end
    if (!stun_fits(BLOCKSTUN_FRAMES)) begin : g_bad_blockstun
        $error("BLOCKSTUN_FRAMES must be in 1..31");
    end

    localparam logic [STUN_W-1:0] HIT_LOAD   = STUN_W'(HITSTUN_FRAMES);
    localparam logic [STUN_W-1:0] BLOCK_LOAD = STUN_W'(BLOCKSTUN_FRAMES);

    // Index 0 is player 1, index 1 is player 2 throughout.
    logic [1:0] w_overlap;     // [a]: attacker a's hitbox overlaps the other's hurtbox
    logic [1:0] w_contact;
    logic [1:0] w_hit_active;
    logic [1:0] w_reg_hit;     // [a]: attacker a registers a hit this tick
    logic [1:0] w_new_hit;     // [v]: victim v takes a hit this tick
    logic [1:0] w_block_req;
    logic [1:0] w_blocked;
    logic [1:0] w_got_hit_next;
    logic [1:0] w_got_block_next;
    logic [1:0] w_hitstun_next;
    logic [1:0] w_eval_ok;
    logic       w_eval;

    logic [1:0]        r_rst_sync;
    atk_state_e        r_state [2];
    atk_state_e        w_state_next [2];
    logic [STUN_W-1:0] r_cnt [2];
    logic [STUN_W-1:0] w_cnt_next [2];
    logic [1:0]        r_in_hitstun;
    logic [1:0]        r_got_hit;
    logic [1:0]        r_got_block;

    box_overlap u_ovl_p1_p2 (
        .i_a_x1    (p1_hit_x1),
        .i_a_x2    (p1_hit_x2),
        .i_a_y1    (p1_hit_y1),
        .i_a_y2    (p1_hit_y2),
        .i_b_x1    (p2_hurt_x1),
        .i_b_x2    (p2_hurt_x2),
        .i_b_y1    (p2_hurt_y1),
        .i_b_y2    (p2_hurt_y2),
        .o_overlap (w_overlap[0])
    );

    box_overlap u_ovl_p2_p1 (
        .i_a_x1    (p2_hit_x1),
        .i_a_x2    (p2_hit_x2),
        .i_a_y1    (p2_hit_y1),
        .i_a_y2    (p2_hit_y2),
        .i_b_x1    (p1_hurt_x1),
        .i_b_x2    (p1_hurt_x2),
        .i_b_y1    (p1_hurt_y1),
        .i_b_y2    (p1_hurt_y2),
        .o_overlap (w_overlap[1])
    );

    assign w_hit_active = {p2_hit_active, p1_hit_active};
    assign w_block_req  = {p2_block_req, p1_block_req};
    assign w_contact[0] = p1_hit_active & p2_hurt_active & w_overlap[0];
    assign w_contact[1] = p2_hit_active & p1_hurt_active & w_overlap[1];
    assign w_new_hit    = {w_reg_hit[0], w_reg_hit[1]};

    // Reset asserts immediately but releases two clocks later, so no tick is
    // evaluated until the synchroniser has filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_eval_ok = r_rst_sync;
    assign w_eval    = frame_tick & w_eval_ok[1];

    // Attacker FSM next state; a hit registers only on entry to StSpent.
    always_comb begin
        w_reg_hit = 2'b00;
        for (int a = 0; a < 2; a++) begin
            w_state_next[a] = r_state[a];
            if (w_eval) begin
                unique case (r_state[a])
                    StIdle: begin
                        if (w_contact[a]) begin
                            w_state_next[a] = StSpent;
                            w_reg_hit[a]    = 1'b1;
                        end else if (w_hit_active[a]) begin
                            w_state_next[a] = StArmed;
                        end
                    end
                    StArmed: begin
                        if (w_contact[a]) begin
                            w_state_next[a] = StSpent;
                            w_reg_hit[a]    = 1'b1;
                        end else if (!w_hit_active[a]) begin
                            w_state_next[a] = StIdle;
                        end
                    end
                    StSpent: begin
                        if (!w_hit_active[a]) w_state_next[a] = StIdle;
                    end
                    default: w_state_next[a] = StIdle;
                endcase
            end
        end
    end

    // Victim stun: a new hit reloads (no accumulation); otherwise count down.
    always_comb begin
        w_blocked        = 2'b00;
        w_got_hit_next   = 2'b00;
        w_got_block_next = 2'b00;
        w_hitstun_next   = r_in_hitstun;
        for (int v = 0; v < 2; v++) begin
            w_cnt_next[v] = r_cnt[v];
            w_blocked[v]  = w_block_req[v] & ~r_in_hitstun[v];
            if (w_new_hit[v]) begin
                if (w_blocked[v]) begin
                    w_got_block_next[v] = 1'b1;
                    w_cnt_next[v]       = BLOCK_LOAD;
                    w_hitstun_next[v]   = 1'b0;
                end else begin
                    w_got_hit_next[v]   = 1'b1;
                    w_cnt_next[v]       = HIT_LOAD;
                    w_hitstun_next[v]   = 1'b1;
                end
            end else if (w_eval && (r_cnt[v] != '0)) begin
                w_cnt_next[v] = r_cnt[v] - 1'b1;
            end
            if (w_cnt_next[v] == '0) w_hitstun_next[v] = 1'b0;
        end
    end

    // State registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= StIdle;
                r_cnt[i]   <= '0;
            end
            r_in_hitstun <= 2'b00;
            r_got_hit    <= 2'b00;
            r_got_block  <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= w_state_next[i];
                r_cnt[i]   <= w_cnt_next[i];
            end
            r_in_hitstun <= w_hitstun_next;
            r_got_hit    <= w_got_hit_next;
            r_got_block  <= w_got_block_next;
        end
    end

    assign p1_got_hit    = r_got_hit[0];
    assign p1_got_block  = r_got_block[0];
    assign p1_stun_cnt   = r_cnt[0];
    assign p1_in_hitstun = r_in_hitstun[0];
    assign p2_got_hit    = r_got_hit[1];
    assign p2_got_block  = r_got_block[1];
    assign p2_stun_cnt   = r_cnt[1];
    assign p2_in_hitstun = r_in_hitstun[1];

endmodule
